// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared datapath constants and types for the register file,
//               ALU and control blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] regidx_t;

    localparam regidx_t REG_ZERO = '0;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/reg_file_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_if
// Description : Read/write bus between decode/writeback and the register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_if
    import cpu_pkg::*;
();

    regidx_t readreg1;
    regidx_t readreg2;
    regidx_t writereg;
    word_t   writedata;
    logic    regwrite;
    word_t   readdata1;
    word_t   readdata2;

    modport master (
        output readreg1,
        output readreg2,
        output writereg,
        output writedata,
        output regwrite,
        input  readdata1,
        input  readdata2
    );

    modport slave (
        input  readreg1,
        input  readreg2,
        input  writereg,
        input  writedata,
        input  regwrite,
        output readdata1,
        output readdata2
    );

endinterface : reg_file_if
`default_nettype wire

// File: rtl/reg_file_rdport.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_rdport
// Description : One combinational read port: index mux, register-0 override
//               and, with REG_FILE_BYPASS_EN defined, write-to-read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_rdport
    import cpu_pkg::*;
(
    input  wire  word_t [NREGS-1:0] i_regs,
    input  wire  regidx_t           i_idx,
`ifdef REG_FILE_BYPASS_EN
    input  wire  logic              i_we,
    input  wire  regidx_t           i_widx,
    input  wire  word_t             i_wdata,
`endif
    output logic [DATA_W-1:0]       o_data
);

    word_t w_data;

    always_comb begin
        w_data = i_regs[i_idx];
`ifdef REG_FILE_BYPASS_EN
        if (i_we && (i_widx == i_idx)) begin
            w_data = i_wdata;
        end
`endif
        // Zero override comes last so register 0 can never be forwarded.
        if (i_idx == REG_ZERO) begin
            w_data = '0;
        end
    end

    assign o_data = w_data;

endmodule : reg_file_rdport
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : 32 x 32-bit register file, two combinational read ports and
//               one synchronous write port; register 0 reads as zero.
//               Optional macro REG_FILE_BYPASS_EN enables write forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file
    import cpu_pkg::*;
(
    input  wire        clk,
    input  wire        rst_n,
    reg_file_if.slave  bus
);

    word_t [NREGS-1:0] w_regs;
    logic  [NREGS-1:0] w_wr_en;

    // Entry 0 has no storage at all, so nothing on the write port can reach it.
    assign w_regs[0]  = '0;
    assign w_wr_en[0] = 1'b0;

    for (genvar gi = 1; gi < NREGS; gi++) begin : g_entry
        word_t r_q;

        assign w_wr_en[gi] = bus.regwrite && (bus.writereg == regidx_t'(gi));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_q <= '0;
            end else if (w_wr_en[gi]) begin
                r_q <= bus.writedata;
            end
        end

        assign w_regs[gi] = r_q;
    end

`ifdef REG_FILE_BYPASS_EN
    logic w_fwd_we;
    assign w_fwd_we = bus.regwrite && (bus.writereg != REG_ZERO);
`endif

    reg_file_rdport u_rdport1 (
        .i_regs  (w_regs),
        .i_idx   (bus.readreg1),
`ifdef REG_FILE_BYPASS_EN
        .i_we    (w_fwd_we),
        .i_widx  (bus.writereg),
        .i_wdata (bus.writedata),
`endif
        .o_data  (bus.readdata1)
    );

    reg_file_rdport u_rdport2 (
        .i_regs  (w_regs),
        .i_idx   (bus.readreg2),
`ifdef REG_FILE_BYPASS_EN
        .i_we    (w_fwd_we),
        .i_widx  (bus.writereg),
        .i_wdata (bus.writedata),
`endif
        .o_data  (bus.readdata2)
    );

endmodule : reg_file
`default_nettype wire
